// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key indices, operator codes,
// debounce state encoding and key decode helpers.
package keypad_pkg;

    // Key index = 4*row + col
    localparam logic [3:0] KEY_1   = 4'd0;
    localparam logic [3:0] KEY_2   = 4'd1;
    localparam logic [3:0] KEY_3   = 4'd2;
    localparam logic [3:0] KEY_ADD = 4'd3;
    localparam logic [3:0] KEY_4   = 4'd4;
    localparam logic [3:0] KEY_5   = 4'd5;
    localparam logic [3:0] KEY_6   = 4'd6;
    localparam logic [3:0] KEY_SUB = 4'd7;
    localparam logic [3:0] KEY_7   = 4'd8;
    localparam logic [3:0] KEY_8   = 4'd9;
    localparam logic [3:0] KEY_9   = 4'd10;
    localparam logic [3:0] KEY_MUL = 4'd11;
    localparam logic [3:0] KEY_C   = 4'd12;
    localparam logic [3:0] KEY_0   = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_DIV = 4'd15;

    localparam logic [1:0] OPT_DIV = 2'd0;
    localparam logic [1:0] OPT_ADD = 2'd1;
    localparam logic [1:0] OPT_SUB = 2'd2;
    localparam logic [1:0] OPT_MUL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PDEB,
        ST_HELD,
        ST_RDEB
    } deb_state_t;

    typedef enum logic [1:0] {
        KC_DIGIT,
        KC_OPER,
        KC_CLEAR,
        KC_SUBMIT
    } key_class_t;

    function automatic key_class_t key_class(input logic [3:0] idx);
        key_class_t kc;
        if (idx == KEY_C)
            kc = KC_CLEAR;
        else if (idx == KEY_EQ)
            kc = KC_SUBMIT;
        else if (idx[1:0] == 2'd3)
            kc = KC_OPER;
        else
            kc = KC_DIGIT;
        return kc;
    endfunction

    function automatic logic [3:0] key_digit(input logic [3:0] idx);
        logic [3:0] d;
        case (idx)
            KEY_1:   d = 4'd1;
            KEY_2:   d = 4'd2;
            KEY_3:   d = 4'd3;
            KEY_4:   d = 4'd4;
            KEY_5:   d = 4'd5;
            KEY_6:   d = 4'd6;
            KEY_7:   d = 4'd7;
            KEY_8:   d = 4'd8;
            KEY_9:   d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] key_opt(input logic [3:0] idx);
        logic [1:0] o;
        case (idx)
            KEY_ADD: o = OPT_ADD;
            KEY_SUB: o = OPT_SUB;
            KEY_MUL: o = OPT_MUL;
            default: o = OPT_DIV;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column drive, row synchronizer and per-scan key result assembly.
// scanDone marks the column-3 sample cycle; the key outputs are valid with it.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       scanDone,
    output logic [3:0] keyIdx,
    output logic       keyFound,
    output logic       keyMulti
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic          acc_found;
    logic          acc_multi;
    logic [3:0]    acc_idx;

    logic          sample;
    logic [3:0]    hits;
    logic [2:0]    hit_cnt;
    logic [1:0]    low_row;
    logic          col_found;
    logic          col_multi;
    logic [3:0]    cur_idx;

    assign sample   = (dwell == DWELL_LAST);
    assign scanDone = sample && (col_idx == 2'd3);
    assign col      = ~(4'b0001 << col_idx);
    assign hits     = ~row_sync;

    always_comb begin
        hit_cnt = {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
        low_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (hits[r])
                low_row = 2'(r);
        end
        col_found = |hits;
        col_multi = (hit_cnt > 3'd1);
        cur_idx   = {low_row, col_idx};
    end

    // Merge this column's sample into the scan so far; keep the lowest index
    always_comb begin
        keyFound = acc_found | col_found;
        keyMulti = acc_multi | col_multi | (acc_found & col_found);
        if (acc_found && (!col_found || (acc_idx < cur_idx)))
            keyIdx = acc_idx;
        else
            keyIdx = cur_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell     <= '0;
            col_idx   <= 2'd0;
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            acc_found <= 1'b0;
            acc_multi <= 1'b0;
            acc_idx   <= 4'd0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (sample) begin
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
                if (scanDone) begin
                    acc_found <= 1'b0;
                    acc_multi <= 1'b0;
                    acc_idx   <= 4'd0;
                end else begin
                    acc_found <= keyFound;
                    acc_multi <= keyMulti;
                    acc_idx   <= keyIdx;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounce FSM and key decode into calculator strobes.
// Define KEYPAD_MULTIKEY_REJECT_EN to treat multi-key scans as no key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] num,
    output logic       numPressed,
    output logic [1:0] opt,
    output logic       optPressed,
    output logic       clear,
    output logic       submit
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    localparam logic MULTI_ACCEPT = 1'b0;
`else
    localparam logic MULTI_ACCEPT = 1'b1;
`endif

    logic       scan_done;
    logic [3:0] key_idx;
    logic       key_found;
    logic       key_multi;
    logic       key_valid;
    logic       key_match;

    deb_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] cand, cand_n;
    logic       fire;
    logic [3:0] fire_key;
    key_class_t fire_class;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .scanDone (scan_done),
        .keyIdx   (key_idx),
        .keyFound (key_found),
        .keyMulti (key_multi)
    );

    // Multi-key scans either resolve to the lowest index or count as no key
    assign key_valid  = key_found & (MULTI_ACCEPT | ~key_multi);
    assign key_match  = key_valid && (key_idx == cand);
    assign fire_class = key_class(fire_key);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        fire     = 1'b0;
        fire_key = cand;
        if (scan_done) begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        cand_n   = key_idx;
                        fire_key = key_idx;
                        if (DEB_TARGET == 4'd1) begin
                            state_n = ST_HELD;
                            cnt_n   = 4'd0;
                            fire    = 1'b1;
                        end else begin
                            state_n = ST_PDEB;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                ST_PDEB: begin
                    if (key_match) begin
                        if (cnt + 4'd1 == DEB_TARGET) begin
                            state_n = ST_HELD;
                            cnt_n   = 4'd0;
                            fire    = 1'b1;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (!key_match) begin
                        if (DEB_TARGET == 4'd1) begin
                            state_n = ST_IDLE;
                            cnt_n   = 4'd0;
                        end else begin
                            state_n = ST_RDEB;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                ST_RDEB: begin
                    if (key_match) begin
                        state_n = ST_HELD;
                        cnt_n   = 4'd0;
                    end else if (cnt + 4'd1 == DEB_TARGET) begin
                        state_n = ST_IDLE;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    // Strobes are registered so they appear the cycle after the scan-end sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            cand       <= 4'd0;
            num        <= 4'd0;
            opt        <= OPT_DIV;
            numPressed <= 1'b0;
            optPressed <= 1'b0;
            clear      <= 1'b0;
            submit     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cand       <= cand_n;
            numPressed <= fire && (fire_class == KC_DIGIT);
            optPressed <= fire && (fire_class == KC_OPER);
            clear      <= fire && (fire_class == KC_CLEAR);
            submit     <= ((state_n == ST_HELD) || (state_n == ST_RDEB)) && (cand_n == KEY_EQ);
            if (fire && (fire_class == KC_DIGIT))
                num <= key_digit(fire_key);
            if (fire && (fire_class == KC_OPER))
                opt <= key_opt(fire_key);
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces presses, and decodes each accepted key into the operand, operator, clear and submit strobes that the calculator control block consumes. It sits directly upstream of the calculator FSM. Its outputs connect one-to-one to the calculator's num/numPressed/opt/optPressed/clear/submit inputs.

## Interface
- SCAN_DIV, 50000: clk cycles each column is driven low; must be >= 4
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release; range 1..15
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- row  in  4  keypad rows; active-low, externally pulled up, asynchronous
- col  out  4  column drive; exactly one bit low at a time
- num  out  4  digit 0..9 of the last accepted digit key; held between events
- numPressed  out  1  one-cycle strobe; digit key accepted
- opt  out  2  operator of the last accepted operator key; held between events
- optPressed  out  1  one-cycle strobe; operator key accepted
- clear  out  1  one-cycle strobe; C key accepted
- submit  out  1  level; high while the = key is accepted and not yet debounced-released

## Operation
- Key map, row r / col c, index = 4r+c:
  - row0: 1 2 3 +
  - row1: 4 5 6 -
  - row2: 7 8 9 x
  - row3: C 0 = /
- Operator codes: + = 1, - = 2, x = 3, / = 0. These match the calculator's add = 1 and sub = 2 coding. All others read as unsupported.
- Column scan: col cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
- row passes through a 2-FF synchronizer. It is sampled on the last cycle of each column dwell.
- A scan result is formed after column 3 is sampled. It is none, a single key index, or multi (more than one row/column hit).
- Debounce FSM, evaluated once per scan-end:
  - IDLE: a single key K loads the candidate, cnt=1 and moves to PDEB. If DEBOUNCE_SCANS=1, it goes directly to HELD and fires the event.
  - PDEB: K seen again increments cnt. When cnt = DEBOUNCE_SCANS, go to HELD and fire the event. Any other result returns to IDLE, cnt=0.
  - HELD: a result other than K moves to RDEB with cnt=1. K seen stays in HELD.
  - RDEB: a result other than K increments cnt. When cnt = DEBOUNCE_SCANS, go to IDLE. K seen returns to HELD with cnt=0.
- Event on entering HELD, depending on the key:
  - digit: num <= digit, numPressed pulse
  - operator: opt <= code, optPressed pulse
  - C: clear pulse
  - =: submit rises and stays high in HELD and RDEB, falling on entry to IDLE
- Once a key is held, a second key pressed while it is held produces no event. A new event requires a return to IDLE.
- Multi-key results are handled according to the Configuration section.

## Timing
- Reset values:
  - col = 1110
  - num = 0, opt = 0
  - all strobes and submit = 0
  - FSM in IDLE, cnt = 0, scan counters = 0
- Full scan = 4*SCAN_DIV cycles.
- Strobes assert the cycle after the scan-end sample that completes debounce and last exactly one cycle.
- Press-to-strobe latency, from a stable press: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scans, plus 3 cycles.
- submit falls 1 cycle after the scan-end that completes release debounce.
- Reset mid-press clears the FSM and outputs immediately. A key still held after reset is re-debounced and re-reported.
- Counters wrap cleanly: the column dwell counter runs 0..SCAN_DIV-1 and the column index runs 0..3.

## Configuration
- KEYPAD_MULTIKEY_REJECT_EN defined: a multi scan result is treated as none, so it aborts PDEB and counts toward release in HELD/RDEB.
- KEYPAD_MULTIKEY_REJECT_EN undefined: a multi result resolves to the lowest hit key index and is then handled as a single key.

## Structure
- Shared package keypad_pkg holds:
  - key index localparams: KEY_C=12, KEY_0=13, KEY_EQ=14, etc.
  - operator codes OPT_ADD=1, OPT_SUB=2, OPT_MUL=3, OPT_DIV=0
  - debounce FSM state encoding
- One sub-module, keypad_col_scan, contains:
  - dwell counter and column drive
  - row synchronizer
  - per-scan result assembly
- keypad_col_scan outputs scanDone (1-cycle), keyIdx[3:0], keyFound and keyMulti.
- The top level holds the debounce FSM and the decode logic.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2.
- Reset: hold reset low for 3 cycles, then release -> col=1110, all outputs 0, col reaches 1101 after 4 cycles.
- Press 7 (row2 low only while col=1110) for 5 scans -> one numPressed pulse with num=7, 2-3 scans after press onset; no further pulses.
- Press - -> one optPressed pulse with opt=2. Then press 5 -> numPressed with num=5, while opt stays 2.
- Bounce: toggle 3 every scan for 6 scans -> no strobes. Then hold it stable for 3 scans -> exactly one pulse with num=3.
- Hold = for 4 scans, then release -> submit high from acceptance until 2 scans of no key plus 1 cycle. C -> a single clear pulse.
- Hold 1 and 2 together:
  - with KEYPAD_MULTIKEY_REJECT_EN -> no event
  - without it -> numPressed with num=1
- Assert reset mid-HELD with 8 held -> outputs clear at once. After release of reset, 8 is reported again.
